// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-stage bundle of imem request/response, redirect, stall and IF/ID outputs
interface if_fetch_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic            if_flush;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_flush,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_flush,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, in-order imem fetch with buffered {pc,instr} output; FETCH_PERF_EN adds perf counters
module if_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_bubbles_o
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q;
    logic            run_q;
    logic            flush_q;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q;
    logic [XLEN-1:0] ring_q [FIFO_DEPTH];
    logic [PW-1:0]   ring_wr_q, ring_rd_q;
    logic [XLEN-1:0] fpc_q [FIFO_DEPTH];
    logic [ILEN-1:0] finstr_q [FIFO_DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   cnt_q;

    logic accept, rsp, push, pop, head_ok;

    // a response with nothing outstanding is a protocol error and is ignored
    assign rsp        = bus.imem_rsp_valid && inflight_q != '0;
    assign push       = rsp && !bus.redirect_valid && discard_q == '0;
    assign head_ok    = cnt_q != '0 && !flush_q;
    assign pop        = head_ok && !bus.stall;
    assign accept     = bus.imem_req_valid && bus.imem_req_ready;
    assign inflight_d = inflight_q + CW'(accept) - CW'(rsp);

    // in-flight plus buffered words never exceed the buffer, so a full FIFO can never overflow
    assign bus.imem_req_valid = run_q && !bus.redirect_valid &&
                                ({1'b0, inflight_q} + {1'b0, cnt_q} < (CW + 1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = head_ok;
    assign bus.if_pc          = head_ok ? fpc_q[head_q] : '0;
    assign bus.if_instr       = head_ok ? finstr_q[head_q] : '0;
    assign bus.if_flush       = flush_q;

    // control state: PC, outstanding/discard accounting, FIFO pointers; redirect overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            run_q      <= 1'b0;
            flush_q    <= 1'b0;
            inflight_q <= '0;
            discard_q  <= '0;
            ring_wr_q  <= '0;
            ring_rd_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            run_q      <= 1'b1;
            flush_q    <= bus.redirect_valid;
            inflight_q <= inflight_d;
            pc_q       <= bus.redirect_valid ? bus.redirect_pc : accept ? pc_q + XLEN'(4) : pc_q;
            discard_q  <= bus.redirect_valid ? inflight_d : discard_q - CW'(rsp && discard_q != '0);
            ring_wr_q  <= ring_wr_q + PW'(accept);
            ring_rd_q  <= ring_rd_q + PW'(rsp);
            head_q     <= bus.redirect_valid ? '0 : head_q + PW'(pop);
            tail_q     <= bus.redirect_valid ? '0 : tail_q + PW'(push);
            cnt_q      <= bus.redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        end
    end

    // storage: request address per in-flight slot, and the {pc,instr} buffer
    always_ff @(posedge clk) begin
        if (accept) ring_q[ring_wr_q] <= pc_q;
        if (push) begin
            fpc_q[tail_q]    <= ring_q[ring_rd_q];
            finstr_q[tail_q] <= bus.imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, bubbles_q;

    // free-running event counters, untouched by redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push);
            bubbles_q <= bubbles_q + 32'(!head_ok && !bus.stall);
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_bubbles_o = bubbles_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a 1-cycle imem model that can be held
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.XLEN(64), .ILEN(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    if_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h100), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched),
        .perf_bubbles_o (perf_bubbles)
`endif
    );

    int          n_checks = 0;
    int          n_pass = 0;
    bit          hold = 1'b0;
    logic [63:0] q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && bus.if_valid !== 1'b1; i++) @(negedge clk);
        check(tag, bus.if_valid, 1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && bus.imem_req_valid !== 1'b1; i++) @(negedge clk);
        check(tag, bus.imem_req_valid, 1);
    endtask

    // imem model: answers each accepted address one cycle later, in order; hold freezes responses
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (bus.imem_rsp_valid) void'(q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) q.push_back(bus.imem_req_addr);
            #1;
            bus.imem_rsp_valid = !hold && q.size() > 0;
            bus.imem_rsp_data  = '0;
            if (bus.imem_rsp_valid) bus.imem_rsp_data = {16'hC0DE, q[0][15:0]};
        end
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;
        @(negedge clk);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_instr", bus.if_instr, 0);
        check("rst_if_flush", bus.if_flush, 0);
        check("rst_req_valid", bus.imem_req_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_valid", bus.imem_req_valid, 1);
        check("first_req_addr", bus.imem_req_addr, 64'h100);
        wait_valid("seq0_valid", 8);
        check("seq0_pc", bus.if_pc, 64'h100);
        check("seq0_instr", bus.if_instr, 64'hC0DE0100);
        @(negedge clk);
        check("seq1_pc", bus.if_pc, 64'h104);
        bus.stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_pc", bus.if_pc, 64'h104);
            check("stall_instr", bus.if_instr, 64'hC0DE0104);
            check("stall_req_valid", bus.imem_req_valid, 0);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        check("rel_pc", bus.if_pc, 64'h108);
        check("rel_req_valid", bus.imem_req_valid, 1);
        check("rel_req_addr", bus.imem_req_addr, 64'h10C);
        @(negedge clk);
        wait_valid("rel2_valid", 8);
        check("rel2_pc", bus.if_pc, 64'h10C);
        hold = 1'b1;
        for (int i = 0; i < 10 && (bus.imem_req_valid || bus.if_valid); i++) @(negedge clk);
        check("hold_idle", {bus.imem_req_valid, bus.if_valid}, 0);
        check("hold_req_addr", bus.imem_req_addr, 64'h11C);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2000;
        #1;
        check("redir_no_req", bus.imem_req_valid, 0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        hold = 1'b0;
        check("redir_flush", bus.if_flush, 1);
        check("redir_if_valid", bus.if_valid, 0);
        check("redir_req_addr", bus.imem_req_addr, 64'h2000);
        check("redir_cap", bus.imem_req_valid, 0);
        @(negedge clk);
        check("redir_flush_1cyc", bus.if_flush, 0);
        wait_valid("redir_valid", 12);
        check("redir_pc", bus.if_pc, 64'h2000);
        check("redir_instr", bus.if_instr, 64'hC0DE2000);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3000;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("nrdy_flush", bus.if_flush, 1);
        repeat (4) begin
            @(negedge clk);
            check("nrdy_addr", bus.imem_req_addr, 64'h3000);
            check("nrdy_if_valid", bus.if_valid, 0);
        end
        bus.imem_req_ready = 1'b1;
        wait_valid("nrdy_valid", 10);
        check("nrdy_pc", bus.if_pc, 64'h3000);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_valid("wrap0_valid", 10);
        check("wrap0_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap0_instr", bus.if_instr, 64'hC0DEFFFC);
        @(negedge clk);
        wait_valid("wrap1_valid", 10);
        check("wrap1_pc", bus.if_pc, 64'h0);
        check("wrap1_instr", bus.if_instr, 64'hC0DE0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_if_valid", bus.if_valid, 0);
        check("mid_rst_if_pc", bus.if_pc, 0);
        check("mid_rst_if_instr", bus.if_instr, 0);
        check("mid_rst_flush", bus.if_flush, 0);
        check("mid_rst_req_valid", bus.imem_req_valid, 0);
        check("mid_rst_req_addr", bus.imem_req_addr, 64'h100);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("post_rst_req", 6);
        check("post_rst_addr", bus.imem_req_addr, 64'h100);
        wait_valid("post_rst_valid", 8);
        check("post_rst_pc", bus.if_pc, 64'h100);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
